// File: rtl/probabilistic_search_controller.sv
// Run sequencer for one MCMC search: fetches u/v costs, drives calculateProbability, and issues accept/reject.
// Optional macro PSC_ACCEPT_STATS_EN adds the out_accept_count statistics output.
module probabilistic_search_controller #(
  parameter int COST_W       = 8,
  parameter int ITER_W       = 16,
  parameter int PROB_LATENCY = 2    // legal range 1..15
) (
  input  logic              in_clock,
  input  logic              in_reset_n,
  input  logic              in_start,
  input  logic [7:0]        in_seed,
  input  logic [ITER_W-1:0] in_max_iter,
  output logic              out_cost_req,
  output logic              out_cost_sel,
  input  logic              in_cost_valid,
  input  logic [COST_W-1:0] in_cost,
  output logic              out_prob_reset,
  output logic              out_prob_enable,
  output logic [7:0]        out_prob_seed,
  output logic [COST_W-1:0] out_prob_u,
  output logic [COST_W-1:0] out_prob_v,
  input  logic [COST_W-1:0] in_prob_p,
  output logic              out_accept,
  output logic              out_reject,
  output logic              out_busy,
  output logic              out_done,
  output logic              out_solved,
  output logic              out_error,
  output logic [ITER_W-1:0] out_iter_count
`ifdef PSC_ACCEPT_STATS_EN
  ,
  output logic [ITER_W-1:0] out_accept_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_COST_CUR,
    S_COST_PROP,
    S_EVAL,
    S_DECIDE,
    S_DONE
  } state_t;

  localparam logic [3:0]        EVAL_LAST = 4'(PROB_LATENCY - 1);
  localparam logic [COST_W-1:0] P_ONE     = COST_W'(1);

  state_t              state, state_d;
  logic [7:0]          seed_q;
  logic [ITER_W-1:0]   max_iter_q;
  logic [COST_W-1:0]   u_q, v_q, p_q;
  logic [3:0]          eval_cnt;
  logic [ITER_W-1:0]   iter_count, iter_next;
  logic                solved_q, error_q;
  logic                cost_hit, eval_last;
`ifdef PSC_ACCEPT_STATS_EN
  logic [ITER_W-1:0]   accept_count;
`endif

  assign cost_hit  = out_cost_req && in_cost_valid;
  assign eval_last = (eval_cnt == EVAL_LAST);
  assign iter_next = (iter_count == '1) ? iter_count : iter_count + ITER_W'(1);

  // NOTE: sequential state is written with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) state <= S_IDLE;
    else             state <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path can infer a latch.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:      if (in_start) state_d = (in_max_iter == '0) ? S_DONE : S_SEED;
      S_SEED:      state_d = S_COST_CUR;
      S_COST_CUR:  if (cost_hit) state_d = (in_cost == '0) ? S_DONE : S_COST_PROP;
      S_COST_PROP: if (cost_hit) state_d = S_EVAL;
      S_EVAL:      if (eval_last) state_d = S_DECIDE;
      S_DECIDE:    state_d = (iter_next == max_iter_q) ? S_DONE : S_COST_CUR;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Datapath registers; all are cleared by reset so an aborted run leaves nothing behind.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      seed_q     <= '0;
      max_iter_q <= '0;
      u_q        <= '0;
      v_q        <= '0;
      p_q        <= '0;
      eval_cnt   <= '0;
      iter_count <= '0;
      solved_q   <= 1'b0;
      error_q    <= 1'b0;
`ifdef PSC_ACCEPT_STATS_EN
      accept_count <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_start) begin
            seed_q     <= in_seed;
            max_iter_q <= in_max_iter;
            iter_count <= '0;
            solved_q   <= 1'b0;
            error_q    <= 1'b0;
`ifdef PSC_ACCEPT_STATS_EN
            accept_count <= '0;
`endif
          end
        end
        S_COST_CUR: begin
          if (cost_hit) begin
            u_q <= in_cost;
            if (in_cost == '0) solved_q <= 1'b1;
          end
        end
        S_COST_PROP: begin
          if (cost_hit) v_q <= in_cost;
        end
        S_EVAL: begin
          // p is only trusted on the final enabled cycle of the window.
          if (eval_last) begin
            p_q      <= in_prob_p;
            eval_cnt <= '0;
          end else begin
            eval_cnt <= eval_cnt + 4'd1;
          end
        end
        S_DECIDE: begin
          iter_count <= iter_next;
          if (p_q > P_ONE) error_q <= 1'b1;
`ifdef PSC_ACCEPT_STATS_EN
          if (p_q == P_ONE && accept_count != '1) accept_count <= accept_count + ITER_W'(1);
`endif
        end
        default: ;
      endcase
    end
  end

  assign out_busy        = (state != S_IDLE);
  assign out_cost_req    = (state == S_COST_CUR) || (state == S_COST_PROP);
  assign out_cost_sel    = (state == S_COST_PROP);
  assign out_prob_reset  = (state == S_SEED);
  assign out_prob_enable = (state == S_EVAL);
  assign out_accept      = (state == S_DECIDE) && (p_q == P_ONE);
  assign out_reject      = (state == S_DECIDE) && (p_q != P_ONE);
  assign out_done        = (state == S_DONE);
  assign out_prob_seed   = seed_q;
  assign out_prob_u      = u_q;
  assign out_prob_v      = v_q;
  assign out_solved      = solved_q;
  assign out_error       = error_q;
  assign out_iter_count  = iter_count;
`ifdef PSC_ACCEPT_STATS_EN
  assign out_accept_count = accept_count;
`endif

endmodule

// File: tb/tb_probabilistic_search_controller.sv
// Scoreboard bench for probabilistic_search_controller: directed runs push expected accept/reject/done events,
// a monitor pops and compares them; mocks model the cost evaluator and calculateProbability.
module tb_probabilistic_search_controller;

  localparam int COST_W = 8;
  localparam int ITER_W = 16;
  localparam int PL     = 2;

  logic              in_clock = 1'b0;
  logic              in_reset_n;
  logic              in_start;
  logic [7:0]        in_seed;
  logic [ITER_W-1:0] in_max_iter;
  logic              out_cost_req, out_cost_sel;
  logic              in_cost_valid;
  logic [COST_W-1:0] in_cost;
  logic              out_prob_reset, out_prob_enable;
  logic [7:0]        out_prob_seed;
  logic [COST_W-1:0] out_prob_u, out_prob_v;
  logic [COST_W-1:0] in_prob_p;
  logic              out_accept, out_reject, out_busy, out_done, out_solved, out_error;
  logic [ITER_W-1:0] out_iter_count;
`ifdef PSC_ACCEPT_STATS_EN
  logic [ITER_W-1:0] out_accept_count;
`endif

  probabilistic_search_controller #(.COST_W(COST_W), .ITER_W(ITER_W), .PROB_LATENCY(PL)) dut (
    .in_clock        (in_clock),
    .in_reset_n      (in_reset_n),
    .in_start        (in_start),
    .in_seed         (in_seed),
    .in_max_iter     (in_max_iter),
    .out_cost_req    (out_cost_req),
    .out_cost_sel    (out_cost_sel),
    .in_cost_valid   (in_cost_valid),
    .in_cost         (in_cost),
    .out_prob_reset  (out_prob_reset),
    .out_prob_enable (out_prob_enable),
    .out_prob_seed   (out_prob_seed),
    .out_prob_u      (out_prob_u),
    .out_prob_v      (out_prob_v),
    .in_prob_p       (in_prob_p),
    .out_accept      (out_accept),
    .out_reject      (out_reject),
    .out_busy        (out_busy),
    .out_done        (out_done),
    .out_solved      (out_solved),
    .out_error       (out_error),
    .out_iter_count  (out_iter_count)
`ifdef PSC_ACCEPT_STATS_EN
    ,
    .out_accept_count(out_accept_count)
`endif
  );

  always #5 in_clock = ~in_clock;

  typedef enum logic [2:0] {EV_ACC = 3'b001, EV_REJ = 3'b010, EV_DONE = 3'b100} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       iter;
    bit       solved;
    bit       error;
  } ev_t;

  ev_t               exp_q[$];
  logic [COST_W-1:0] p_seq[$];
  int unsigned       checks = 0;
  int unsigned       failures = 0;

  logic [COST_W-1:0] u_val = '0, v_val = '0;
  logic [7:0]        exp_seed = '0;
  int                stall_cfg = 0;
  bit                stray_en = 1'b0;
  int                rst_cycles = 0, en_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input ev_kind_t k, input int it, input bit s, input bit e);
    ev_t ev;
    ev.kind = k; ev.iter = it; ev.solved = s; ev.error = e;
    exp_q.push_back(ev);
  endtask

  // Scoreboard monitor: every accept/reject/done pulse must match the next expected event.
  initial forever begin
    @(negedge in_clock);
    if (in_reset_n && (out_accept || out_reject || out_done)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {29'b0, out_done, out_reject, out_accept}, 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("event_kind", {29'b0, out_done, out_reject, out_accept}, {29'b0, e.kind});
        check("event_iter_count", 32'(out_iter_count), e.iter);
        check("event_solved", {31'b0, out_solved}, {31'b0, e.solved});
        check("event_error", {31'b0, out_error}, {31'b0, e.error});
      end
    end
  end

  // Probability-interface monitor: seed during load, u/v during the enable window.
  initial forever begin
    @(negedge in_clock);
    if (out_prob_reset) begin
      rst_cycles++;
      check("prob_seed", {24'b0, out_prob_seed}, {24'b0, exp_seed});
    end
    if (out_prob_enable) begin
      en_cycles++;
      check("prob_u", {24'b0, out_prob_u}, {24'b0, u_val});
      check("prob_v", {24'b0, out_prob_v}, {24'b0, v_val});
    end
  end

  // Cost evaluator mock: optional stall per request, optional stray valid while req is low.
  initial begin
    int stall_left;
    stall_left    = 0;
    in_cost_valid = 1'b0;
    in_cost       = 8'hEE;
    forever begin
      @(negedge in_clock);
      if (out_cost_req) begin
        if (stall_left > 0) begin
          in_cost_valid = 1'b0;
          in_cost       = 8'hEE;
          stall_left--;
        end else begin
          in_cost_valid = 1'b1;
          in_cost       = out_cost_sel ? v_val : u_val;
          stall_left    = stall_cfg;
        end
      end else begin
        stall_left = stall_cfg;
        in_cost    = 8'hEE;
        if (stray_en && out_busy) begin
          in_cost_valid = 1'b1;
          stray_en      = 1'b0;
        end else begin
          in_cost_valid = 1'b0;
        end
      end
    end
  end

  // calculateProbability mock: the real decision appears only on the last enabled cycle.
  initial begin
    int                en_run;
    logic [COST_W-1:0] dropped;
    en_run    = 0;
    in_prob_p = 8'hAA;
    forever begin
      @(negedge in_clock);
      if ((out_accept || out_reject) && p_seq.size() > 0) dropped = p_seq.pop_front();
      if (out_prob_enable) begin
        if (en_run == PL - 1 && p_seq.size() > 0) in_prob_p = p_seq[0];
        else                                       in_prob_p = 8'hAA;
        en_run++;
      end else begin
        en_run    = 0;
        in_prob_p = 8'hAA;
      end
    end
  end

  // Start pulse; afterwards the seed/limit inputs are scrambled to prove they were captured.
  task automatic start_run(input logic [7:0] seed, input logic [ITER_W-1:0] max_it);
    exp_seed    = seed;
    in_seed     = seed;
    in_max_iter = max_it;
    in_start    = 1'b1;
    @(negedge in_clock);
    in_start    = 1'b0;
    in_seed     = ~seed;
    in_max_iter = max_it + ITER_W'(1);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!out_done && n < 300) begin
      @(negedge in_clock);
      n++;
    end
    check({name, "_done_seen"}, {31'b0, out_done}, 32'd1);
    #1;
    check({name, "_scoreboard_empty"}, exp_q.size(), 32'd0);
    @(negedge in_clock);
    check({name, "_idle_after_done"}, {30'b0, out_busy, out_done}, 32'd0);
  endtask

  initial begin
    int r0, e0, n;
    in_reset_n  = 1'b0;
    in_start    = 1'b0;
    in_seed     = '0;
    in_max_iter = '0;
    repeat (2) @(negedge in_clock);
    check("reset_ctrl_outputs",
          {23'b0, out_busy, out_done, out_accept, out_reject, out_cost_req, out_prob_reset,
           out_prob_enable, out_solved, out_error}, 32'd0);
    check("reset_iter_count", 32'(out_iter_count), 32'd0);
    check("reset_seed_u_v", {8'b0, out_prob_seed, out_prob_u, out_prob_v}, 32'd0);
    in_reset_n = 1'b1;
    @(negedge in_clock);

    // max_iter = 0: done one cycle after start, probability block never touched.
    r0 = rst_cycles; e0 = en_cycles;
    push(EV_DONE, 0, 0, 0);
    start_run(8'h33, 16'd0);
    check("max0_done_next_cycle", {31'b0, out_done}, 32'd1);
    wait_done("max0");
    check("max0_no_prob_reset", rst_cycles - r0, 32'd0);
    check("max0_no_prob_enable", en_cycles - e0, 32'd0);

    // Reset asserted mid-EVAL aborts the run immediately with no pulses.
    u_val = 8'd6; v_val = 8'd4;
    p_seq.push_back(8'd1);
    start_run(8'h11, 16'd4);
    n = 0;
    while (!out_prob_enable && n < 50) begin
      @(negedge in_clock);
      n++;
    end
    check("abort_reached_eval", {31'b0, out_prob_enable}, 32'd1);
    #2 in_reset_n = 1'b0;
    #1;
    check("abort_ctrl_outputs",
          {23'b0, out_busy, out_done, out_accept, out_reject, out_cost_req, out_prob_reset,
           out_prob_enable, out_solved, out_error}, 32'd0);
    check("abort_seed_u_v", {8'b0, out_prob_seed, out_prob_u, out_prob_v}, 32'd0);
    @(negedge in_clock);
    in_reset_n = 1'b1;
    p_seq.delete();
    repeat (3) @(negedge in_clock);
    check("abort_stays_idle", {31'b0, out_busy}, 32'd0);

    // Single iteration, zero-wait costs, p = 1.
    r0 = rst_cycles; e0 = en_cycles;
    u_val = 8'd5; v_val = 8'd6;
    p_seq.push_back(8'd1);
    push(EV_ACC, 0, 0, 0);
    push(EV_DONE, 1, 0, 0);
    start_run(8'h01, 16'd1);
    wait_done("single");
    check("single_prob_reset_cycles", rst_cycles - r0, 32'd1);
    check("single_prob_enable_cycles", en_cycles - e0, PL);

    // Cost handshake with stalls and a stray valid pulse, p = 0.
    u_val = 8'd7; v_val = 8'd9;
    stall_cfg = 3; stray_en = 1'b1;
    p_seq.push_back(8'd0);
    push(EV_REJ, 0, 0, 0);
    push(EV_DONE, 1, 0, 0);
    start_run(8'h42, 16'd1);
    wait_done("stall");
    stall_cfg = 0;

    // Multi-iteration run, p = 1,0,0,1; seed loaded once per run.
    r0 = rst_cycles; e0 = en_cycles;
    u_val = 8'd6; v_val = 8'd4;
    p_seq.push_back(8'd1); p_seq.push_back(8'd0); p_seq.push_back(8'd0); p_seq.push_back(8'd1);
    push(EV_ACC, 0, 0, 0);
    push(EV_REJ, 1, 0, 0);
    push(EV_REJ, 2, 0, 0);
    push(EV_ACC, 3, 0, 0);
    push(EV_DONE, 4, 0, 0);
    start_run(8'h5A, 16'd4);
    wait_done("multi");
    check("multi_prob_reset_cycles", rst_cycles - r0, 32'd1);
    check("multi_prob_enable_cycles", en_cycles - e0, 4 * PL);
`ifdef PSC_ACCEPT_STATS_EN
    check("multi_accept_count", 32'(out_accept_count), 32'd2);
`endif

    // Early solve: first u = 0 ends the run before any evaluation.
    e0 = en_cycles;
    u_val = 8'd0; v_val = 8'd4;
    push(EV_DONE, 0, 1, 0);
    start_run(8'h77, 16'd3);
    wait_done("solve");
    check("solve_no_prob_enable", en_cycles - e0, 32'd0);
    check("solve_sticky", {31'b0, out_solved}, 32'd1);

    // Bad p = 3: reject plus sticky error; solved cleared by the new start.
    u_val = 8'd3; v_val = 8'd2;
    p_seq.push_back(8'd3); p_seq.push_back(8'd0);
    push(EV_REJ, 0, 0, 0);
    push(EV_REJ, 1, 0, 1);
    push(EV_DONE, 2, 0, 1);
    start_run(8'h09, 16'd2);
    wait_done("badp");
`ifdef PSC_ACCEPT_STATS_EN
    check("badp_accept_count_cleared", 32'(out_accept_count), 32'd0);
`endif
    repeat (3) @(negedge in_clock);
    check("badp_error_sticky", {31'b0, out_error}, 32'd1);

    // Next start clears the error flag.
    push(EV_DONE, 0, 0, 0);
    start_run(8'h10, 16'd0);
    wait_done("clear");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
